// File: rtl/exec_monitor_pkg.sv
// Shared types and constants for the execution monitor.
// Holds the sequencer state encoding, status codes and the default mailbox address.
// No logic lives here.
package exec_monitor_pkg;

   typedef enum logic [2:0] {
      ST_STARTUP = 3'd0,
      ST_HOLD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_PASS    = 3'd3,
      ST_FAIL    = 3'd4,
      ST_TIMEOUT = 3'd5
   } state_t;

   localparam logic [1:0] STATUS_RUN     = 2'd0;
   localparam logic [1:0] STATUS_PASS    = 2'd1;
   localparam logic [1:0] STATUS_FAIL    = 2'd2;
   localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

   localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/exec_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and variable increment.
// Latency: new value visible the cycle after the enabling edge.
// No backpressure; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH:0]   w_sum;

   // One extra bit catches the carry that signals saturation.
   assign w_sum = {1'b0, r_count} + {1'b0, i_inc};

   // Counter register: clear has priority, then saturating accumulate.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/exec_monitor.sv
// Sequences processor reset and watches the tohost mailbox to decide pass/fail/timeout.
// Latency: a mailbox hit or timeout is registered on the sampling edge, visible next cycle.
// No backpressure; monitored ports are observed only, never stalled.
module exec_monitor
   import exec_monitor_pkg::*;
#(
   parameter int                 XLEN           = 32,
   parameter int                 NUM_RETIRE     = 1,
   parameter int unsigned        STARTUP_CYCLES = 10,
   parameter int unsigned        RESET_CYCLES   = 1,
   parameter int unsigned        TIMEOUT_CYCLES = 125000,
   parameter logic [XLEN-1:0]    TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR)
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic [NUM_RETIRE-1:0] i_retire_valid,
   input  logic                  i_store_valid,
   input  logic [XLEN-1:0]       i_store_addr,
   input  logic [XLEN/8-1:0]     i_store_strobe,
   input  logic [XLEN-1:0]       i_store_data,
   output logic                  o_core_reset,
   output logic                  o_done,
   output logic [1:0]            o_status,
   output logic [XLEN-2:0]       o_fail_code,
   output logic [31:0]           o_cycle_count,
   output logic [31:0]           o_instret_count
);

   // Phase-counter terminal values; zero-length phases still take one edge.
   localparam logic [31:0] STARTUP_LAST = (STARTUP_CYCLES > 1) ? 32'(STARTUP_CYCLES - 1) : 32'd0;
   localparam logic [31:0] RESET_LAST   = (RESET_CYCLES > 1)   ? 32'(RESET_CYCLES - 1)   : 32'd0;
   localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   localparam logic [XLEN-1:0] PASS_DATA = {{(XLEN-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [31:0]       r_phase;
   logic              r_core_reset;
   logic              r_done;
   logic [1:0]        r_status;
   logic [XLEN-2:0]   r_fail_code;

   logic              w_in_run;
   logic              w_hit;
   logic              w_timeout;
   logic [31:0]       w_retire_cnt;
   logic [31:0]       w_cycle_count;
   logic [31:0]       w_instret_count;

   assign w_in_run = (r_state == ST_RUN);

   // Only a full-word write with the LSB set to the mailbox address ends the run.
   assign w_hit = w_in_run && i_store_valid && (i_store_addr == TOHOST_ADDR) &&
                  (&i_store_strobe) && i_store_data[0];

   // The count reaches TIMEOUT_CYCLES on this edge, i.e. the last allowed RUN cycle.
   assign w_timeout = w_in_run && (TIMEOUT_CYCLES != 0) && (w_cycle_count == TIMEOUT_LAST);

   // Number of instructions retired this cycle.
   always_comb begin
      w_retire_cnt = '0;
      for (int i = 0; i < NUM_RETIRE; i++) begin
         w_retire_cnt = w_retire_cnt + 32'(i_retire_valid[i]);
      end
   end

   // Sequencer: startup window, core reset pulse, run, then sticky verdict.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= ST_STARTUP;
         r_phase      <= '0;
         r_core_reset <= 1'b0;
         r_done       <= 1'b0;
         r_status     <= STATUS_RUN;
         r_fail_code  <= '0;
      end else begin
         case (r_state)
            ST_STARTUP: begin
               if (r_phase == STARTUP_LAST) begin
                  r_state      <= ST_HOLD;
                  r_phase      <= '0;
                  r_core_reset <= 1'b1;
               end else begin
                  r_phase <= r_phase + 32'd1;
               end
            end
            ST_HOLD: begin
               if (r_phase == RESET_LAST) begin
                  r_state      <= ST_RUN;
                  r_phase      <= '0;
                  r_core_reset <= 1'b0;
               end else begin
                  r_phase <= r_phase + 32'd1;
               end
            end
            ST_RUN: begin
               if (w_hit) begin
                  r_done       <= 1'b1;
                  r_core_reset <= 1'b1;
                  if (i_store_data == PASS_DATA) begin
                     r_state  <= ST_PASS;
                     r_status <= STATUS_PASS;
                  end else begin
                     r_state     <= ST_FAIL;
                     r_status    <= STATUS_FAIL;
                     r_fail_code <= i_store_data[XLEN-1:1];
                  end
               end else if (w_timeout) begin
                  r_state      <= ST_TIMEOUT;
                  r_status     <= STATUS_TIMEOUT;
                  r_done       <= 1'b1;
                  r_core_reset <= 1'b1;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   sat_counter #(.WIDTH(32)) u_cycle_cnt (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_clear   (r_state == ST_STARTUP),
      .i_enable  (w_in_run),
      .i_inc     (32'd1),
      .o_count   (w_cycle_count)
   );

   sat_counter #(.WIDTH(32)) u_instret_cnt (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_clear   (r_state == ST_STARTUP),
      .i_enable  (w_in_run),
      .i_inc     (w_retire_cnt),
      .o_count   (w_instret_count)
   );

   assign o_core_reset    = r_core_reset;
   assign o_done          = r_done;
   assign o_status        = r_status;
   assign o_fail_code     = r_fail_code;
   assign o_cycle_count   = w_cycle_count;
   assign o_instret_count = w_instret_count;

endmodule

// File: tb/tb_exec_monitor.sv
// Directed bench for exec_monitor: two instances with different phase parameters.
// Main instance: 2 retire strobes, 200-cycle timeout; second: no startup, 3-cycle hold, no timeout.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_exec_monitor;

   logic        clk;
   logic        rst_n;
   logic [1:0]  retire;
   logic        st_vld;
   logic [31:0] st_addr;
   logic [3:0]  st_strb;
   logic [31:0] st_data;

   logic        core_reset, done;
   logic [1:0]  status;
   logic [30:0] fail_code;
   logic [31:0] cyc, inst;

   logic        b_core_reset, b_done;
   logic [1:0]  b_status;
   logic [30:0] b_fail_code;
   logic [31:0] b_cyc, b_inst;

   int n_checks = 0;
   int n_pass   = 0;

   exec_monitor #(
      .NUM_RETIRE(2), .STARTUP_CYCLES(10), .RESET_CYCLES(1), .TIMEOUT_CYCLES(200)
   ) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_retire_valid(retire),
      .i_store_valid(st_vld), .i_store_addr(st_addr), .i_store_strobe(st_strb),
      .i_store_data(st_data), .o_core_reset(core_reset), .o_done(done),
      .o_status(status), .o_fail_code(fail_code), .o_cycle_count(cyc),
      .o_instret_count(inst)
   );

   exec_monitor #(
      .NUM_RETIRE(1), .STARTUP_CYCLES(0), .RESET_CYCLES(3), .TIMEOUT_CYCLES(0)
   ) dut_b (
      .i_clock(clk), .i_reset_n(rst_n), .i_retire_valid(retire[0:0]),
      .i_store_valid(st_vld), .i_store_addr(st_addr), .i_store_strobe(st_strb),
      .i_store_data(st_data), .o_core_reset(b_core_reset), .o_done(b_done),
      .o_status(b_status), .o_fail_code(b_fail_code), .o_cycle_count(b_cyc),
      .o_instret_count(b_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_store();
      st_vld  = 1'b0;
      st_addr = 32'h0;
      st_strb = 4'h0;
      st_data = 32'h0;
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      st_vld  = 1'b1;
      st_addr = a;
      st_strb = s;
      st_data = d;
   endtask

   // Hold reset for two edges, release just after an edge.
   task automatic apply_reset();
      rst_n  = 1'b0;
      retire = 2'b00;
      clear_store();
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Main instance reaches RUN after 11 edges (10 startup + 1 hold).
   task automatic reset_to_run();
      apply_reset();
      for (int i = 0; i < 11; i++) step();
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      retire = 2'b00;
      clear_store();
      #1;
      n_checks++; if ({core_reset, done, status} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {core_reset, done, status}); else n_pass++;
      n_checks++; if ({cyc, inst} !== 64'd0) $display("FAIL reset_counts: got %0d/%0d want 0/0", cyc, inst); else n_pass++;
      n_checks++; if (fail_code !== 31'd0) $display("FAIL reset_fail_code: got %0d want 0", fail_code); else n_pass++;
      n_checks++; if ({b_core_reset, b_done, b_status, b_cyc} !== 36'd0) $display("FAIL reset_b: got %h want 0", {b_core_reset, b_done, b_status, b_cyc}); else n_pass++;
   endtask

   task automatic test_startup();
      apply_reset();
      for (int e = 1; e <= 12; e++) begin
         step();
         n_checks++; if (core_reset !== (e == 10)) $display("FAIL startup_core_reset edge %0d: got %b want %b", e, core_reset, (e == 10)); else n_pass++;
         n_checks++; if (b_core_reset !== (e >= 1 && e <= 3)) $display("FAIL startup_b_core_reset edge %0d: got %b want %b", e, b_core_reset, (e >= 1 && e <= 3)); else n_pass++;
         if (e == 11) begin
            n_checks++; if (cyc !== 32'd0) $display("FAIL startup_cyc_at_run_entry: got %0d want 0", cyc); else n_pass++;
         end
      end
      n_checks++; if (cyc !== 32'd1) $display("FAIL startup_cyc_first_run: got %0d want 1", cyc); else n_pass++;
      n_checks++; if (b_cyc !== 32'd8) $display("FAIL startup_b_cyc: got %0d want 8", b_cyc); else n_pass++;
   endtask

   task automatic test_pass();
      reset_to_run();
      retire = 2'b11;
      for (int i = 0; i < 49; i++) step();
      n_checks++; if ({done, status} !== 3'b000) $display("FAIL pass_pre_done: got %b want 000", {done, status}); else n_pass++;
      n_checks++; if (inst !== 32'd98) $display("FAIL pass_pre_inst: got %0d want 98", inst); else n_pass++;
      drive_store(32'h1000, 4'hF, 32'h1);
      step();
      clear_store();
      n_checks++; if ({done, status} !== 3'b101) $display("FAIL pass_status: got %b want 101", {done, status}); else n_pass++;
      n_checks++; if (cyc !== 32'd50) $display("FAIL pass_cyc: got %0d want 50", cyc); else n_pass++;
      n_checks++; if (inst !== 32'd100) $display("FAIL pass_inst: got %0d want 100", inst); else n_pass++;
      n_checks++; if (core_reset !== 1'b1) $display("FAIL pass_core_reset: got %b want 1", core_reset); else n_pass++;
      n_checks++; if ({b_done, b_status} !== 3'b101) $display("FAIL pass_b_status: got %b want 101", {b_done, b_status}); else n_pass++;
      n_checks++; if (b_cyc !== 32'd57) $display("FAIL pass_b_cyc: got %0d want 57", b_cyc); else n_pass++;
      n_checks++; if (b_inst !== 32'd50) $display("FAIL pass_b_inst: got %0d want 50", b_inst); else n_pass++;
      // Terminal state must ignore a later failing write and further retirements.
      drive_store(32'h1000, 4'hF, 32'h2B);
      for (int i = 0; i < 5; i++) step();
      clear_store();
      n_checks++; if ({done, status, cyc, inst} !== {1'b1, 2'd1, 32'd50, 32'd100}) $display("FAIL pass_sticky: got %b/%0d/%0d want 101/50/100", {done, status}, cyc, inst); else n_pass++;
      n_checks++; if (fail_code !== 31'd0) $display("FAIL pass_sticky_fail_code: got %0d want 0", fail_code); else n_pass++;
   endtask

   task automatic test_fail();
      reset_to_run();
      retire = 2'b01;
      step();
      step();
      drive_store(32'h1000, 4'hF, 32'h0000_002B);
      n_checks++; if (done !== 1'b0) $display("FAIL fail_pre_done: got %b want 0", done); else n_pass++;
      step();
      clear_store();
      n_checks++; if ({done, status} !== 3'b110) $display("FAIL fail_status: got %b want 110", {done, status}); else n_pass++;
      n_checks++; if (fail_code !== 31'd21) $display("FAIL fail_code: got %0d want 21", fail_code); else n_pass++;
      n_checks++; if ({cyc, inst} !== {32'd3, 32'd3}) $display("FAIL fail_counts: got %0d/%0d want 3/3", cyc, inst); else n_pass++;
      n_checks++; if (core_reset !== 1'b1) $display("FAIL fail_core_reset: got %b want 1", core_reset); else n_pass++;
   endtask

   task automatic test_ignored();
      apply_reset();
      n_checks++; if (fail_code !== 31'd0) $display("FAIL ign_fail_code_cleared: got %0d want 0", fail_code); else n_pass++;
      // A passing write and retirements during startup/hold must have no effect.
      retire = 2'b11;
      drive_store(32'h1000, 4'hF, 32'h1);
      for (int i = 0; i < 11; i++) step();
      clear_store();
      n_checks++; if ({done, status, core_reset} !== 4'b0) $display("FAIL ign_startup_ctrl: got %b want 0000", {done, status, core_reset}); else n_pass++;
      n_checks++; if ({cyc, inst} !== 64'd0) $display("FAIL ign_startup_counts: got %0d/%0d want 0/0", cyc, inst); else n_pass++;
      retire = 2'b10;
      for (int i = 0; i < 4; i++) step();
      drive_store(32'h1000, 4'h3, 32'h1); step();
      drive_store(32'h1004, 4'hF, 32'h1); step();
      drive_store(32'h1000, 4'hF, 32'h2); step();
      drive_store(32'h1000, 4'hF, 32'h1); st_vld = 1'b0; step();
      clear_store();
      n_checks++; if ({done, status} !== 3'b000) $display("FAIL ign_no_term: got %b want 000", {done, status}); else n_pass++;
      n_checks++; if (cyc !== 32'd8) $display("FAIL ign_cyc8: got %0d want 8", cyc); else n_pass++;
      for (int i = 0; i < 191; i++) step();
      n_checks++; if ({done, status} !== 3'b000) $display("FAIL ign_pre_timeout: got %b want 000", {done, status}); else n_pass++;
      step();
      n_checks++; if ({done, status} !== 3'b111) $display("FAIL ign_timeout_status: got %b want 111", {done, status}); else n_pass++;
      n_checks++; if ({cyc, inst} !== {32'd200, 32'd200}) $display("FAIL ign_timeout_counts: got %0d/%0d want 200/200", cyc, inst); else n_pass++;
      n_checks++; if (core_reset !== 1'b1) $display("FAIL ign_timeout_core_reset: got %b want 1", core_reset); else n_pass++;
      for (int i = 0; i < 3; i++) step();
      n_checks++; if (cyc !== 32'd200) $display("FAIL ign_frozen_cyc: got %0d want 200", cyc); else n_pass++;
   endtask

   task automatic test_hit_vs_timeout();
      reset_to_run();
      for (int i = 0; i < 199; i++) step();
      drive_store(32'h1000, 4'hF, 32'h1);
      step();
      clear_store();
      n_checks++; if ({done, status} !== 3'b101) $display("FAIL hvt_status: got %b want 101", {done, status}); else n_pass++;
      n_checks++; if ({cyc, inst} !== {32'd200, 32'd0}) $display("FAIL hvt_counts: got %0d/%0d want 200/0", cyc, inst); else n_pass++;
   endtask

   task automatic test_midrun_reset();
      reset_to_run();
      retire = 2'b11;
      for (int i = 0; i < 30; i++) step();
      n_checks++; if ({cyc, inst} !== {32'd30, 32'd60}) $display("FAIL mid_pre_counts: got %0d/%0d want 30/60", cyc, inst); else n_pass++;
      rst_n = 1'b0;
      #2;
      n_checks++; if ({core_reset, done, status, cyc, inst} !== 68'd0) $display("FAIL mid_async_clear: got %b/%0d/%0d want 0/0/0", {core_reset, done, status}, cyc, inst); else n_pass++;
      step();
      rst_n  = 1'b1;
      retire = 2'b00;
      for (int i = 0; i < 9; i++) step();
      n_checks++; if (core_reset !== 1'b0) $display("FAIL mid_restart_startup: got %b want 0", core_reset); else n_pass++;
      step();
      n_checks++; if (core_reset !== 1'b1) $display("FAIL mid_restart_hold: got %b want 1", core_reset); else n_pass++;
      step();
      n_checks++; if ({core_reset, cyc} !== 33'd0) $display("FAIL mid_restart_run: got %b/%0d want 0/0", core_reset, cyc); else n_pass++;
      step();
      n_checks++; if (cyc !== 32'd1) $display("FAIL mid_restart_cyc: got %0d want 1", cyc); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_pass();
      test_fail();
      test_ignored();
      test_hit_vs_timeout();
      test_midrun_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
